fifo_lvl: RTL and testbench

- Parametrised synchronous FIFO, successor to the basic UART-path FIFO.
- Adds: occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Serves as the RX/TX buffer between the UART core and the stop-watch/command logic; the thresholds drive flow control and burst reads.
- Show-ahead read port: rd_data always presents the head entry.

---
 rtl/fifo_lvl_regfile.sv | 34 +++
 rtl/fifo_lvl.sv | 133 +++++++++++++
 tb/tb_fifo_lvl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_lvl_regfile.sv
// fifo_lvl_regfile: storage array for fifo_lvl.
//   2**W entries of B bits, one synchronous write port and one
//   asynchronous (combinational) read port so the FIFO head is visible
//   without a read cycle.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   [W-1:0] write address
//   wdata  in   [B-1:0] write data
//   raddr  in   [W-1:0] read address
//   rdata  out  [B-1:0] read data, combinational from mem[raddr]
module fifo_lvl_regfile #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem [2**W];

  // NOTE: the array has no reset; contents are only meaningful once written,
  // and leaving it unreset lets synthesis map it to plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: parametrised synchronous show-ahead FIFO with occupancy count,
//   almost-full/almost-empty thresholds, synchronous flush and sticky
//   overflow/underflow flags.
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   flush         in   synchronous clear of contents (wins over wr/rd)
//   wr, wr_data   in   write request and data
//   rd            in   pop request
//   rd_data       out  head entry (undefined when empty)
//   full, empty   out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_THR
//   almost_empty  out  count <= AE_THR
//   count         out  [W:0] stored entries
//   overflow      out  sticky: write rejected while full
//   underflow     out  sticky: read rejected while empty
//   clr_err       in   synchronous clear of overflow/underflow
module fifo_lvl #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_THR = 2**W - 2,
  parameter int AE_THR = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr,
  input  logic [B-1:0] wr_data,
  input  logic         rd,
  output logic [B-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam logic [W:0] DEPTH_C = (W+1)'(2**W);
  localparam logic [W:0] AF_C    = (W+1)'(AF_THR);
  localparam logic [W:0] AE_C    = (W+1)'(AE_THR);

  logic [W-1:0] wr_ptr_q, wr_ptr_d;
  logic [W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         af_q, af_d;
  logic         ae_q, ae_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  logic         wr_acc, rd_acc, we;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    // Accept decisions use the registered flags; a full FIFO still takes a
    // write when a pop frees the head slot in the same cycle.
    wr_acc   = wr & (~full_q | rd);
    rd_acc   = rd & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + W'(1);
      count_d = count_q + (W+1)'(wr_acc) - (W+1)'(rd_acc);
    end

    // Flags are registered from the next count so they line up with it.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // A new error event wins over a coincident clear; flush masks detection.
    overflow_d  = (~flush & wr & full_q & ~rd) | (overflow_q  & ~clr_err);
    underflow_d = (~flush & rd & empty_q)      | (underflow_q & ~clr_err);

    we = wr_acc & ~flush;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_lvl_regfile #(.B(B), .W(W)) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed bench for fifo_lvl (B=8, W=4). A queue-based model
// of the FIFO is compared against the DUT on every falling edge; literal
// checks along the directed sequence pin the model itself.
module tb_fifo_lvl;

  localparam int B     = 8;
  localparam int W     = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush, wr, rd, clr_err;
  logic [B-1:0] wr_data;
  logic [B-1:0] rd_data;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;
  logic [W:0]   count;

  int checks = 0;
  int errors = 0;

  fifo_lvl #(.B(B), .W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr           (wr),
    .wr_data      (wr_data),
    .rd           (rd),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [B-1:0] mq[$];
  logic         m_ovf, m_unf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit was_full, was_empty, ovf_ev, unf_ev;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      ovf_ev    = !flush && wr && was_full && !rd;
      unf_ev    = !flush && rd && was_empty;
      if (flush) begin
        mq.delete();
      end else begin
        if (rd && !was_empty) void'(mq.pop_front());
        if (wr && (!was_full || rd)) mq.push_back(wr_data);
      end
      m_ovf = ovf_ev ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_unf = unf_ev ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_full", 32'(full), 32'(mq.size() == DEPTH));
      check("m_afull", 32'(almost_full), 32'(mq.size() >= AF));
      check("m_aempty", 32'(almost_empty), 32'(mq.size() <= AE));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_unf", 32'(underflow), 32'(m_unf));
      if (mq.size() > 0) check("m_rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs away from the edge, then return just after it.
  task automatic step(input logic w, input logic r, input logic [B-1:0] d,
                      input logic f = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    #1;
    wr = w; rd = r; wr_data = d; flush = f; clr_err = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill: 0x11..0x1F, then the 16th word.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 + i));
      if (i == 12) check("fill13_afull", 32'(almost_full), 0);
      if (i == 13) check("fill14_afull", 32'(almost_full), 1);
    end
    check("fill15_count", 32'(count), 15);
    check("fill15_full", 32'(full), 0);
    check("fill15_head", 32'(rd_data), 32'h11);
    step(1'b1, 1'b0, 8'h20);
    check("fill16_full", 32'(full), 1);
    check("fill16_count", 32'(count), 16);

    // Overflow on full, then clear.
    step(1'b1, 1'b0, 8'hAA);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Full FIFO, simultaneous rd/wr replaces all entries with 0x55.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'h55);
      check("rw_full", 32'(full), 1);
    end
    for (int i = 0; i < 16; i++) begin
      check("drain55", 32'(rd_data), 32'h55);
      step(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(empty), 1);

    // Empty FIFO, simultaneous rd/wr: only the write lands.
    step(1'b1, 1'b1, 8'h3C);
    check("rw_empty_unf", 32'(underflow), 1);
    check("rw_empty_count", 32'(count), 1);
    check("rw_empty_data", 32'(rd_data), 32'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("unf_clr", 32'(underflow), 0);
    check("pop3c_empty", 32'(empty), 1);

    // Five words, then read past empty.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 1));
    for (int i = 0; i < 6; i++) begin
      if (i < 5) check("r5_data", 32'(rd_data), 32'(i + 1));
      step(1'b0, 1'b1, 8'h00);
      if (i == 0) check("r5_aempty_c4", 32'(almost_empty), 0);
      if (i == 3) check("r5_aempty_c1", 32'(almost_empty), 1);
      if (i == 4) check("r5_empty", 32'(empty), 1);
      if (i == 4) check("r5_no_unf", 32'(underflow), 0);
      if (i == 5) check("r6_unf", 32'(underflow), 1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap-around: three batches of 10 in / 10 out.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + 16 * k + i));
      for (int i = 0; i < 10; i++) begin
        check("wrap_data", 32'(rd_data), 32'(8'h40 + 16 * k + i));
        step(1'b0, 1'b1, 8'h00);
      end
    end

    // Flush mid-stream with a write pending; sticky underflow must survive.
    step(1'b0, 1'b1, 8'h00);
    check("pre_flush_unf", 32'(underflow), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b0, 8'h99, 1'b1);
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_aempty", 32'(almost_empty), 1);
    check("flush_unf_kept", 32'(underflow), 1);
    check("flush_ovf_kept", 32'(overflow), 0);
    step(1'b0, 1'b0, 8'h00);
    check("flush_discard", 32'(count), 0);

    // Async reset in the middle of a write burst, between clock edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hE0 + i));
    wr = 1'b1; wr_data = 8'hEE;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_aempty", 32'(almost_empty), 1);
    check("arst_full", 32'(full), 0);
    check("arst_afull", 32'(almost_full), 0);
    check("arst_unf", 32'(underflow), 0);
    wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
